// File: rtl/rv_fetch_unit_if.sv
// Signal bundle for rv_fetch_unit: imem request/response, redirect strobe,
// decode handshake, plus read-only debug taps of the fetch unit's internal state.
interface rv_fetch_unit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high at the rising edge. Once valid is raised, payload is held stable until
  // the transfer. The imem response channel has no ready and is always consumed.
  logic            ImemReqValid;
  logic            ImemReqReady;
  logic [XLEN-1:0] ImemReqAddr;
  logic            ImemRspValid;
  logic [31:0]     ImemRspData;
  logic            RedirectValid;
  logic [XLEN-1:0] RedirectPc;
  logic            InstrValid;
  logic            InstrReady;
  logic [31:0]     Instr;
  logic [XLEN-1:0] InstrPc;
  logic            InstrFault;
  logic [7:0]      DbgOutCnt;
  logic [7:0]      DbgDropCnt;
  logic            DbgHalted;
  logic [1:0]      DbgState;

  modport master (
    output ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPc, InstrFault,
           DbgOutCnt, DbgDropCnt, DbgHalted, DbgState,
    input  ImemReqReady, ImemRspValid, ImemRspData, RedirectValid, RedirectPc,
           InstrReady
  );

  modport slave (
    input  ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPc, InstrFault,
           DbgOutCnt, DbgDropCnt, DbgHalted, DbgState,
    output ImemReqReady, ImemRspValid, ImemRspData, RedirectValid, RedirectPc,
           InstrReady
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// RV32I instruction fetch unit: credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module rv_fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic             Clk,
  input logic             Reset,
  rv_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

  // Halt FSM: ST_FAULT waits for stale responses to drain before pushing the marker.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]       state_q, state_d;

  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];

  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_misaligned;
  logic             redirect;
  logic             halted;
  logic [CNT_W:0]   credit_sum;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_valid;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             fault_push;
  logic             push;
  logic             pop;
  logic             head_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic             fifo_fault_q [FIFO_DEPTH];
  assign redirect_pc         = bus.RedirectPc;
  assign redirect_misaligned = |bus.RedirectPc[1:0];
`else
  logic             unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.RedirectPc[1:0];
  assign redirect_pc         = {bus.RedirectPc[XLEN-1:2], 2'b00};
  assign redirect_misaligned = 1'b0;
`endif

  assign redirect   = bus.RedirectValid;
  assign halted     = (state_q != ST_RUN);
  assign rsp_valid  = bus.ImemRspValid;
  assign head_valid = (fifo_cnt_q != '0);

  // FIFO space is reserved at request time, so an accepted response always fits.
  assign credit_sum = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign req_valid  = !Reset && !halted && !redirect &&
                      (out_cnt_q < MAX_OUT) && (credit_sum < DEPTH_SUM);
  assign req_fire   = req_valid && bus.ImemReqReady;

  assign rsp_keep   = rsp_valid && (drop_cnt_q == '0);
  assign rsp_drop   = rsp_valid && (drop_cnt_q != '0);
  assign fault_push = (state_q == ST_FAULT) && (drop_cnt_q == '0) && !redirect;
  assign push       = !redirect && (rsp_keep || fault_push);
  assign pop        = !redirect && head_valid && bus.InstrReady;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    state_d    = state_q;

    if (redirect) begin
      // Everything still in flight is stale; the response arriving now is already gone.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      out_cnt_d  = rsp_valid ? (out_cnt_q - CNT_ONE) : out_cnt_q;
      drop_cnt_d = rsp_valid ? (out_cnt_q - CNT_ONE) : out_cnt_q;
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      state_d    = redirect_misaligned ? ST_FAULT : ST_RUN;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;

      if (req_fire && !rsp_valid) begin
        out_cnt_d = out_cnt_q + CNT_ONE;
      end else if (!req_fire && rsp_valid) begin
        out_cnt_d = out_cnt_q - CNT_ONE;
      end

      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_ONE;

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      end else if (!push && pop) begin
        fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      end

      if (fault_push) state_d = ST_HALT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      state_q    <= ST_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      state_q    <= state_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by fifo_cnt_q and outputs are gated.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= fault_push ? 32'h0 : bus.ImemRspData;
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      fifo_fault_q[wr_ptr_q] <= fault_push;
`endif
    end
  end

  assign bus.ImemReqValid = req_valid;
  assign bus.ImemReqAddr  = fetch_pc_q;
  assign bus.InstrValid   = head_valid;
  assign bus.Instr        = head_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign bus.InstrPc      = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.InstrFault   = head_valid && fifo_fault_q[rd_ptr_q];
`else
  assign bus.InstrFault   = 1'b0;
`endif

  assign bus.DbgOutCnt    = 8'(out_cnt_q);
  assign bus.DbgDropCnt   = 8'(drop_cnt_q);
  assign bus.DbgHalted    = halted;
  assign bus.DbgState     = state_q;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: behavioural in-order imem with programmable latency,
// hand-computed expectations checked with immediate assertions.
module tb_rv_fetch_unit;
  localparam int XLEN = 32;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  rv_fetch_unit_if #(.XLEN(XLEN)) bus ();

  rv_fetch_unit #(
    .XLEN           (XLEN),
    .FIFO_DEPTH     (4),
    .MAX_OUTSTANDING(2),
    .RESET_PC       (32'h0)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int cyc = 0;
  int base;
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] acc_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset             = 1'b1;
    bus.ImemReqReady  = 1'b0;
    bus.InstrReady    = 1'b0;
    bus.RedirectValid = 1'b0;
    bus.RedirectPc    = '0;
    repeat (3) tick();
  endtask

  task automatic check_reset_state(input string tag);
    settle();
    chk({tag, "_req_valid"}, bus.ImemReqValid, 0);
    chk({tag, "_req_addr"},  bus.ImemReqAddr, 32'h0);
    chk({tag, "_instr_vld"}, bus.InstrValid, 0);
    chk({tag, "_instr"},     bus.Instr, 32'h0);
    chk({tag, "_instr_pc"},  bus.InstrPc, 32'h0);
    chk({tag, "_fault"},     bus.InstrFault, 0);
    chk({tag, "_out_cnt"},   bus.DbgOutCnt, 0);
    chk({tag, "_drop_cnt"},  bus.DbgDropCnt, 0);
    chk({tag, "_halted"},    bus.DbgHalted, 0);
  endtask

  // Accepted-request monitor: records address and due cycle of every handshake.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        pend_addr_q.delete();
        pend_due_q.delete();
      end else if (bus.ImemReqValid && bus.ImemReqReady) begin
        pend_addr_q.push_back(bus.ImemReqAddr);
        pend_due_q.push_back(cyc + mem_lat);
        acc_log.push_back(bus.ImemReqAddr);
      end
    end
  end

  // In-order memory response driver.
  initial begin
    bus.ImemRspValid = 1'b0;
    bus.ImemRspData  = '0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
        bus.ImemRspValid = 1'b1;
        bus.ImemRspData  = mem_word(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end else begin
        bus.ImemRspValid = 1'b0;
        bus.ImemRspData  = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    check_reset_state("rst");

    // Sequential fetch, latency 1, decode always ready
    mem_lat = 1;
    tick();
    Reset = 1'b0; bus.ImemReqReady = 1'b1; bus.InstrReady = 1'b1;
    settle();
    chk("seq_first_valid", bus.ImemReqValid, 1);
    chk("seq_first_addr",  bus.ImemReqAddr, 32'h0);
    chk("seq_c0_ivalid",   bus.InstrValid, 0);
    tick(); settle();
    chk("seq_c1_addr",     bus.ImemReqAddr, 32'h4);
    chk("seq_c1_ivalid",   bus.InstrValid, 0);
    tick(); settle();
    chk("seq_c2_addr",     bus.ImemReqAddr, 32'h8);
    chk("seq_c2_ivalid",   bus.InstrValid, 1);
    chk("seq_c2_pc",       bus.InstrPc, 32'h0);
    chk("seq_c2_instr",    bus.Instr, 32'h0000_0013);
    for (int i = 1; i < 4; i++) begin
      tick(); settle();
      chk("seq_stream_ivalid", bus.InstrValid, 1);
      chk("seq_stream_pc",     bus.InstrPc, 32'(i * 4));
      chk("seq_stream_addr",   bus.ImemReqAddr, 32'(i * 4 + 8));
    end

    // Redirect together with a response, a pop and a ready memory
    tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'h40;
    settle();
    chk("rdr_same_noreq",  bus.ImemReqValid, 0);
    chk("rdr_same_ivalid", bus.InstrValid, 1);
    tick();
    bus.RedirectValid = 1'b0;
    settle();
    chk("rdr_same_flushed", bus.InstrValid, 0);
    chk("rdr_same_out",     bus.DbgOutCnt, 0);
    chk("rdr_same_drop",    bus.DbgDropCnt, 0);
    chk("rdr_same_valid",   bus.ImemReqValid, 1);
    chk("rdr_same_addr",    bus.ImemReqAddr, 32'h40);
    tick(); settle();
    chk("rdr_same_addr2",   bus.ImemReqAddr, 32'h44);
    tick(); settle();
    chk("rdr_same_pc",      bus.InstrPc, 32'h40);
    chk("rdr_same_instr",   bus.Instr, 32'h0000_0053);

    // FIFO fill with decode stalled; reset mid-stream discards everything
    do_reset();
    check_reset_state("rst2");
    tick();
    Reset = 1'b0; bus.ImemReqReady = 1'b1; bus.InstrReady = 1'b0;
    base = acc_log.size();
    repeat (10) tick();
    chk("fill_accepted", 32'(acc_log.size() - base), 32'd4);
    bus.InstrReady = 1'b1;
    settle();
    chk("fill_full_novalid", bus.ImemReqValid, 0);
    chk("fill_head_pc",      bus.InstrPc, 32'h0);
    tick();
    bus.InstrReady = 1'b0;
    settle();
    chk("fill_pop_valid",    bus.ImemReqValid, 1);
    chk("fill_pop_addr",     bus.ImemReqAddr, 32'h10);
    chk("fill_pop_head",     bus.InstrPc, 32'h4);
    tick(); settle();
    chk("fill_refull",       bus.ImemReqValid, 0);
    tick();
    chk("fill_accepted2", 32'(acc_log.size() - base), 32'd5);

    // Latency 3, two outstanding, redirect drops both
    mem_lat = 3;
    do_reset();
    Reset = 1'b0; bus.ImemReqReady = 1'b1; bus.InstrReady = 1'b1;
    base = acc_log.size();
    tick(); tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'h100;
    settle();
    chk("drop2_out",      bus.DbgOutCnt, 2);
    chk("drop2_noreq",    bus.ImemReqValid, 0);
    tick();
    bus.RedirectValid = 1'b0;
    settle();
    chk("drop2_dropcnt",  bus.DbgDropCnt, 2);
    chk("drop2_addr",     bus.ImemReqAddr, 32'h100);
    for (int i = 0; i < 20 && !bus.InstrValid; i++) begin
      tick(); settle();
    end
    chk("drop2_ivalid",   bus.InstrValid, 1);
    chk("drop2_pc",       bus.InstrPc, 32'h100);
    chk("drop2_instr",    bus.Instr, 32'h0000_0113);
    tick();
    chk("drop2_req_addr", acc_log[base + 2], 32'h100);

    // Latency 3, redirect while a response arrives: DropCnt = OutCnt - 1
    do_reset();
    Reset = 1'b0; bus.ImemReqReady = 1'b1; bus.InstrReady = 1'b1;
    tick(); tick(); tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'h80;
    settle();
    chk("drop1_out_pre",  bus.DbgOutCnt, 2);
    chk("drop1_noreq",    bus.ImemReqValid, 0);
    tick();
    bus.RedirectValid = 1'b0;
    settle();
    chk("drop1_out",      bus.DbgOutCnt, 1);
    chk("drop1_drop",     bus.DbgDropCnt, 1);
    chk("drop1_ivalid0",  bus.InstrValid, 0);
    chk("drop1_valid",    bus.ImemReqValid, 1);
    chk("drop1_addr",     bus.ImemReqAddr, 32'h80);
    for (int i = 0; i < 20 && !bus.InstrValid; i++) begin
      tick(); settle();
    end
    chk("drop1_pc",       bus.InstrPc, 32'h80);
    chk("drop1_instr",    bus.Instr, 32'h0000_0093);

    // Address wrap at the top of the address space
    mem_lat = 1;
    do_reset();
    Reset = 1'b0; bus.ImemReqReady = 1'b0; bus.InstrReady = 1'b1;
    settle();
    chk("wrap_pending",   bus.ImemReqValid, 1);
    tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'hFFFF_FFFC;
    settle();
    chk("wrap_rdr_noreq", bus.ImemReqValid, 0);
    tick();
    bus.RedirectValid = 1'b0; bus.ImemReqReady = 1'b1;
    settle();
    chk("wrap_addr_top",  bus.ImemReqAddr, 32'hFFFF_FFFC);
    tick(); settle();
    chk("wrap_addr_zero", bus.ImemReqAddr, 32'h0);
    tick(); settle();
    chk("wrap_pc_top",    bus.InstrPc, 32'hFFFF_FFFC);
    chk("wrap_instr_top", bus.Instr, 32'hFFFF_FFEF);
    tick(); settle();
    chk("wrap_pc_zero",   bus.InstrPc, 32'h0);

    // Misaligned redirect
    tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'h102;
    settle();
    chk("mis_rdr_noreq",  bus.ImemReqValid, 0);
    tick();
    bus.RedirectValid = 1'b0;
    settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_halt_noreq", bus.ImemReqValid, 0);
    chk("mis_halted",     bus.DbgHalted, 1);
    tick(); settle();
    chk("mis_ivalid",     bus.InstrValid, 1);
    chk("mis_fault",      bus.InstrFault, 1);
    chk("mis_pc",         bus.InstrPc, 32'h102);
    chk("mis_instr",      bus.Instr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      chk("mis_stay_halt",  bus.ImemReqValid, 0);
      chk("mis_fifo_empty", bus.InstrValid, 0);
    end
`else
    chk("mis_valid",      bus.ImemReqValid, 1);
    chk("mis_addr",       bus.ImemReqAddr, 32'h100);
    chk("mis_halted",     bus.DbgHalted, 0);
    tick(); settle();
    chk("mis_addr2",      bus.ImemReqAddr, 32'h104);
    tick(); settle();
    chk("mis_pc",         bus.InstrPc, 32'h100);
    chk("mis_fault",      bus.InstrFault, 0);
`endif
    tick();
    bus.RedirectValid = 1'b1; bus.RedirectPc = 32'h200;
    tick();
    bus.RedirectValid = 1'b0;
    settle();
    chk("resume_valid",   bus.ImemReqValid, 1);
    chk("resume_addr",    bus.ImemReqAddr, 32'h200);
    chk("resume_halted",  bus.DbgHalted, 0);
    tick(); tick(); settle();
    chk("resume_ivalid",  bus.InstrValid, 1);
    chk("resume_pc",      bus.InstrPc, 32'h200);
    chk("resume_fault",   bus.InstrFault, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Parametrised instruction fetch unit for the next-generation pipelined RV32I core. Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel with several reads in flight. Buffers returned instructions with their PCs in a prefetch FIFO, and feeds decode through a valid/ready handshake. Accepts redirects from execute for taken branches and jumps, and discards stale in-flight responses.

## Interface
- `XLEN`, 32: address/data width.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered memory requests, 1..`FIFO_DEPTH`.
- `RESET_PC`, 0: fetch address after reset.

- `Clk` in 1: clock, all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `ImemReqValid` out 1: request valid.
- `ImemReqReady` in 1: memory accepts request.
- `ImemReqAddr` out XLEN: word-aligned fetch address.
- `ImemRspValid` in 1: response valid; no back-pressure, always consumed.
- `ImemRspData` in 32: instruction word.
- `RedirectValid` in 1: single-cycle redirect strobe.
- `RedirectPc` in XLEN: new fetch address.
- `InstrValid` out 1: FIFO head valid.
- `InstrReady` in 1: decode consumes head.
- `Instr` out 32: head instruction.
- `InstrPc` out XLEN: head PC.
- `InstrFault` out 1: head is a misaligned-fetch marker (macro-dependent).

## Operation
- State: `FetchPc`, `RspPc` (PC of next expected response), `OutCnt`, `DropCnt`, FIFO (instr, pc, fault), `Halted`.
- Issue: `ImemReqValid` = !Reset && !Halted && !RedirectValid && OutCnt < MAX_OUTSTANDING && (OutCnt + FifoCount) < FIFO_DEPTH. FIFO space is reserved per request, so a response never overflows.
- Request handshake (`ImemReqValid && ImemReqReady`): FetchPc += 4 (mod 2^XLEN, wrap allowed), OutCnt++.
- Responses are in order, one per accepted request, latency ≥1 cycle. If DropCnt>0: DropCnt--, OutCnt--, discard. Otherwise push {ImemRspData, RspPc, 0}, RspPc += 4, OutCnt--.
- Pop: `InstrValid && InstrReady` removes the head. Push and pop in the same cycle are legal at any occupancy.
- Redirect has priority over all same-cycle events. It flushes the FIFO, including any same-cycle pop and push. It sets FetchPc = RspPc = RedirectPc, DropCnt = OutCnt minus 1 if a response arrives this cycle, and OutCnt = that DropCnt value. No request issues in the redirect cycle.
- A redirect while DropCnt>0 accumulates correctly: all older responses are dropped.

## Timing
- Reset values: ImemReqValid 0, ImemReqAddr RESET_PC, InstrValid 0, Instr 0, InstrPc 0, InstrFault 0, OutCnt 0, DropCnt 0, Halted 0.
- First request is asserted in the first cycle after Reset deasserts.
- Response to InstrValid: 1 cycle, registered FIFO with no bypass.
- Redirect to next request: 1 cycle.
- Back-to-back issue: one request per cycle while credits allow.
- Steady state with 1-cycle memory and MAX_OUTSTANDING≥2: one instruction per cycle.
- Reset mid-operation discards all FIFO contents and counters. Responses to pre-reset requests that arrive after reset are the memory's responsibility: the memory is reset on the same signal.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: a redirect with RedirectPc[1:0]≠0 sets Halted=1. Once DropCnt reaches 0, a single entry {Instr=0, InstrPc=RedirectPc, InstrFault=1} is pushed. No requests issue until the next redirect, which clears Halted.
- Not defined: RedirectPc[1:0] is forced to 0, InstrFault is tied to 0, and Halted is never set.

## Test plan
- Reset, ImemReqReady=1, memory latency 1 returning 0x00000013 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; InstrValid with InstrPc=0x0 two cycles after the first request; one instruction per cycle thereafter.
- InstrReady=0, FIFO_DEPTH=4 -> exactly 4 requests accepted, then ImemReqValid=0. One pop -> one new request next cycle.
- Memory latency 3, two outstanding, RedirectValid with RedirectPc=0x100 -> both old responses dropped; next request addr 0x100; first InstrPc=0x100.
- Redirect in the same cycle as a response, a pop and an ImemReqReady -> FIFO empty next cycle, DropCnt=OutCnt-1, no request in the redirect cycle.
- FetchPc at 0xFFFFFFFC -> next request addr 0x00000000.
- Macro defined, RedirectPc=0x102 -> one InstrFault=1 entry with InstrPc=0x102, then no requests until a redirect to 0x200 resumes fetch. Macro undefined, same stimulus -> requests at 0x100.
